// File: rtl/ysyx_24110006_fetch_queue.sv
// Decoupling queue between the IFU and the IDU. It holds fetched {pc, inst, exception, mcause, predict} packets.
// After a faulting fetch it refuses further packets until the faulting packet has been popped.
module ysyx_24110006_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_inst,
  input  logic             i_exception,
  input  logic [3:0]       i_mcause,
  input  logic             i_predict,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_inst,
  output logic             o_exception,
  output logic [3:0]       o_mcause,
  output logic             o_predict,
  input  logic             i_flush,
  output logic [PTR_W:0]   o_count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [3:0]  mcause;
    logic        predict;
  } pkt_t;

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  pkt_t           entry_q [DEPTH];
  pkt_t           in_pkt;
  pkt_t           head;
  logic [PTR_W:0] wp_q, wp_d;
  logic [PTR_W:0] rp_q, rp_d;
  logic           exc_held_q, exc_held_d;
  logic           empty, full, push, pop;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[PTR_W-1:0] == rp_q[PTR_W-1:0]) && (wp_q[PTR_W] != rp_q[PTR_W]);

  // Ready depends only on registered state and reset, so there is no combinational path from i_valid.
  assign o_ready = !full && !exc_held_q && i_reset;
  assign o_valid = !empty;
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;
  assign o_count = wp_q - rp_q;

  assign in_pkt = '{pc: i_pc, inst: i_inst, exc: i_exception, mcause: i_mcause, predict: i_predict};
  assign head   = entry_q[rp_q[PTR_W-1:0]];

  assign o_pc        = head.pc;
  assign o_inst      = head.inst;
  assign o_exception = head.exc;
  assign o_mcause    = head.mcause;
  assign o_predict   = head.predict;

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    exc_held_d = exc_held_q;
    if (i_flush) begin
      wp_d       = '0;
      rp_d       = '0;
      exc_held_d = 1'b0;
    end else begin
      if (pop) begin
        rp_d = rp_q + PTR_ONE;
        if (head.exc) exc_held_d = 1'b0;
      end
      if (push) begin
        wp_d = wp_q + PTR_ONE;
        if (i_exception) exc_held_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      wp_q       <= '0;
      rp_q       <= '0;
      exc_held_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      exc_held_q <= exc_held_d;
    end
  end

  // Each slot owns its own write enable; a flush suppresses the push in that cycle.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge i_clock) begin
        if (!i_reset) begin
          entry_q[gi] <= '0;
        end else if (push && !i_flush && (wp_q[PTR_W-1:0] == PTR_W'(gi))) begin
          entry_q[gi] <= in_pkt;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ysyx_24110006_fetch_queue.sv
// Bench for ysyx_24110006_fetch_queue: directed scenarios plus a randomized run.
// Both are checked against a queue-based reference model.
module tb_ysyx_24110006_fetch_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, in_exc, in_pred, out_ready_in, flush;
  logic [31:0]      in_pc, in_inst;
  logic [3:0]       in_mc;
  logic             o_ready, o_valid, o_exception, o_predict;
  logic [31:0]      o_pc, o_inst;
  logic [3:0]       o_mcause;
  logic [PTR_W:0]   o_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [3:0]  mc;
    logic        pred;
  } pkt_t;

  pkt_t mq[$];
  bit   m_held;
  bit   m_clean;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ysyx_24110006_fetch_queue #(.DEPTH(DEPTH)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_valid(in_valid), .o_ready(o_ready),
    .i_pc(in_pc), .i_inst(in_inst), .i_exception(in_exc), .i_mcause(in_mc),
    .i_predict(in_pred), .o_valid(o_valid), .i_ready(out_ready_in),
    .o_pc(o_pc), .o_inst(o_inst), .o_exception(o_exception), .o_mcause(o_mcause),
    .o_predict(o_predict), .i_flush(flush), .o_count(o_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare DUT outputs with the model while the current inputs are applied.
  task automatic model_check();
    bit exp_ready;
    exp_ready = (mq.size() < DEPTH) && !m_held && rst_n;
    chk("o_ready", o_ready, exp_ready);
    chk("o_valid", o_valid, mq.size() != 0);
    chk("o_count", o_count, mq.size());
    if (mq.size() != 0) begin
      chk("o_pc", o_pc, mq[0].pc);
      chk("o_inst", o_inst, mq[0].inst);
      chk("o_exception", o_exception, mq[0].exc);
      chk("o_mcause", o_mcause, mq[0].mc);
      chk("o_predict", o_predict, mq[0].pred);
    end else if (m_clean) begin
      chk("reset_payload", {o_pc, o_inst}, 64'h0);
      chk("reset_flags", {o_exception, o_mcause, o_predict}, 6'h0);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] inst, input bit exc,
                      input logic [3:0] mc, input bit pred, input bit rdy, input bit fl, input bit rn);
    bit   acc;
    pkt_t p;
    in_valid = v; in_pc = pc; in_inst = inst; in_exc = exc; in_mc = mc; in_pred = pred;
    out_ready_in = rdy; flush = fl; rst_n = rn;
    #1;
    model_check();
    acc = v && (mq.size() < DEPTH) && !m_held && rn;
    @(posedge clk);
    if (!rn) begin
      mq.delete(); m_held = 0; m_clean = 1;
    end else if (fl) begin
      mq.delete(); m_held = 0;
    end else begin
      if (rdy && mq.size() != 0) begin
        p = mq.pop_front();
        if (p.exc) m_held = 0;
      end
      if (acc) begin
        mq.push_back('{pc: pc, inst: inst, exc: exc, mc: mc, pred: pred});
        if (exc) m_held = 1;
        m_clean = 0;
      end
    end
    #1;
    $display("step v=%0b pc=%08h rdy=%0b fl=%0b rst_n=%0b -> count=%0d o_valid=%0b o_pc=%08h",
             v, pc, rdy, fl, rn, o_count, o_valid, o_pc);
  endtask

  task automatic idle(input bit rdy);
    step(0, 32'h0, 32'h0, 0, 4'h0, 0, rdy, 0, 1);
  endtask

  task automatic push(input logic [31:0] pc, input bit rdy);
    step(1, pc, pc ^ 32'h13, 0, 4'h0, pc[2], rdy, 0, 1);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_pc = 0; in_inst = 0; in_exc = 0; in_mc = 0; in_pred = 0;
    out_ready_in = 0; flush = 0; m_held = 0; m_clean = 0;

    // Reset: even with a push offered, nothing enters.
    step(1, 32'hDEAD0000, 32'h1, 0, 4'h0, 0, 0, 0, 0);
    step(0, 32'h0, 32'h0, 0, 4'h0, 0, 0, 0, 0);
    rst_n = 1; #1;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_count", o_count, 0);
    chk("rst_pc", o_pc, 32'h0);

    // Single push with latency 1.
    step(1, 32'h80000000, 32'h00000413, 0, 4'h0, 0, 0, 0, 1);
    chk("first_valid", o_valid, 1'b1);
    chk("first_pc", o_pc, 32'h80000000);
    chk("first_inst", o_inst, 32'h00000413);
    chk("first_count", o_count, 1);
    idle(1);

    // Fill to DEPTH, then drain in order.
    for (int k = 0; k < 4; k++) push(32'h100 + 32'(4 * k), 0);
    chk("full_ready", o_ready, 1'b0);
    chk("full_count", o_count, 4);
    step(1, 32'h999, 32'h0, 0, 4'h0, 0, 0, 0, 1);   // refused while full
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc", o_pc, 32'h100 + 32'(4 * k));
      idle(1);
    end
    chk("drain_empty", o_valid, 1'b0);

    // Sustained push+pop at count 2 across pointer wrap.
    push(32'h300, 0);
    push(32'h304, 0);
    for (int k = 0; k < 10; k++) begin
      chk("stream_pc", o_pc, 32'h300 + 32'(4 * k));
      push(32'h308 + 32'(4 * k), 1);
      chk("stream_count", o_count, 2);
    end
    idle(1); idle(1);

    // Faulting fetch blocks further pushes until it is popped.
    step(1, 32'h200, 32'h0, 1, 4'h1, 0, 0, 0, 1);
    chk("exc_ready", o_ready, 1'b0);
    push(32'h204, 0);
    chk("exc_blocked_count", o_count, 1);
    chk("exc_head_exc", o_exception, 1'b1);
    chk("exc_head_mcause", o_mcause, 4'h1);
    push(32'h204, 1);
    chk("exc_release_ready", o_ready, 1'b1);
    chk("exc_release_count", o_count, 0);

    // Flush beats a concurrent push and pop.
    push(32'h400, 0); push(32'h404, 0); push(32'h408, 0);
    step(1, 32'h40C, 32'h0, 0, 4'h0, 0, 1, 1, 1);
    chk("flush_count", o_count, 0);
    chk("flush_valid", o_valid, 1'b0);
    chk("flush_ready", o_ready, 1'b1);

    // Reset mid-stream during a pop.
    push(32'h500, 0); push(32'h504, 0);
    step(0, 32'h0, 32'h0, 0, 4'h0, 0, 1, 0, 0);
    rst_n = 1; #1;
    chk("midrst_count", o_count, 0);
    chk("midrst_valid", o_valid, 1'b0);
    chk("midrst_pc", o_pc, 32'h0);
    push(32'h600, 0);
    chk("post_rst_pc", o_pc, 32'h600);
    chk("post_rst_count", o_count, 1);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(3) != 0, $urandom, $urandom, $urandom_range(7) == 0,
           4'($urandom), 1'($urandom), $urandom_range(2) != 0,
           $urandom_range(15) == 0, $urandom_range(31) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
